// File: rtl/bus_ctrl_pkg.sv
// Shared types and address map for the 68000 bus cycle controller.
// Provides the region/state enums, address-hi constants and the decoder.
package bus_ctrl_pkg;

   typedef enum logic [2:0] {
      R_ROM,
      R_RAM,
      R_TICK,
      R_CRTC,
      R_TILE,
      R_PAL,
      R_NONE
   } region_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_IACK,
      S_BERR
   } state_e;

   // Address bits [23:16] of each device window.
   localparam logic [7:0] AH_ROM_LAST = 8'h0F;
   localparam logic [7:0] AH_RAM      = 8'h10;
   localparam logic [7:0] AH_TICK     = 8'h20;
   localparam logic [7:0] AH_CRTC     = 8'h80;
   localparam logic [7:0] AH_TILE     = 8'h90;
   localparam logic [7:0] AH_PAL      = 8'h91;

   // Function code driven by the CPU during interrupt acknowledge.
   localparam logic [2:0] FC_IACK = 3'b111;

   // Address-hi to region decode.
   function automatic region_e decode(input logic [7:0] a);
      region_e r;
      r = R_NONE;
      if (a <= AH_ROM_LAST) begin
         r = R_ROM;
      end else if (a == AH_RAM) begin
         r = R_RAM;
      end else if (a == AH_TICK) begin
         r = R_TICK;
      end else if (a == AH_CRTC) begin
         r = R_CRTC;
      end else if (a == AH_TILE) begin
         r = R_TILE;
      end else if (a == AH_PAL) begin
         r = R_PAL;
      end
      return r;
   endfunction

   // Region to one-hot select {pal,tile,crtc,tick,ram,rom}.
   function automatic logic [5:0] sel_of(input region_e r);
      logic [5:0] s;
      case (r)
         R_ROM:   s = 6'b000001;
         R_RAM:   s = 6'b000010;
         R_TICK:  s = 6'b000100;
         R_CRTC:  s = 6'b001000;
         R_TILE:  s = 6'b010000;
         R_PAL:   s = 6'b100000;
         default: s = 6'b000000;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cpu_bus_ctrl.sv
// Bus cycle controller: device selects, wait states, DTACK/VPA/BERR.
// Ports: clk, reset (async high), as_n, ds_n[1:0], rw, fc[2:0],
//   addr_hi[7:0], tile_ready -> sel[5:0], dtack_n, vpa_n, berr_n, busy.
module cpu_bus_ctrl
   import bus_ctrl_pkg::*;
#(
   parameter logic [3:0]  WS_ROM  = 4'd1,
   parameter logic [3:0]  WS_RAM  = 4'd0,
   parameter logic [3:0]  WS_TICK = 4'd0,
   parameter logic [3:0]  WS_CRTC = 4'd1,
   parameter logic [3:0]  WS_TILE = 4'd2,
   parameter logic [3:0]  WS_PAL  = 4'd1,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       as_n,
   input  logic [1:0] ds_n,
   input  logic       rw,
   input  logic [2:0] fc,
   input  logic [7:0] addr_hi,
   input  logic       tile_ready,
   output logic [5:0] sel,
   output logic       dtack_n,
   output logic       vpa_n,
   output logic       berr_n,
   output logic       busy
);

   localparam logic [7:0] TC_LAST = 8'(TIMEOUT - 1);

   state_e     state_q;
   state_e     state_d;
   region_e    region_q;
   region_e    region_d;
   region_e    region_now;
   region_e    sel_region;
   logic       rw_q;
   logic       rw_d;
   logic [3:0] wcnt_q;
   logic [3:0] wcnt_d;
   logic [7:0] tcnt_q;
   logic [7:0] tcnt_d;
   logic       dtack_q;
   logic       vpa_q;
   logic       berr_q;
   logic       ready;
   logic       term;
   logic       unused_rw;

   function automatic logic [3:0] ws_of(input region_e r);
      logic [3:0] w;
      case (r)
         R_ROM:   w = WS_ROM;
         R_RAM:   w = WS_RAM;
         R_TICK:  w = WS_TICK;
         R_CRTC:  w = WS_CRTC;
         R_TILE:  w = WS_TILE;
         R_PAL:   w = WS_PAL;
         default: w = 4'd0;
      endcase
      return w;
   endfunction

   assign region_now = decode(addr_hi);

   // Cycle ends when the address strobe or both data strobes go high.
   assign term = as_n || (ds_n == 2'b11);

   // Direction is captured for the cycle but no device path uses it yet.
   assign unused_rw = rw_q;

   // Selects follow the live address only while idle; once a cycle
   // starts, the latched region holds them stable.
   assign sel_region = (state_q == S_IDLE) ? region_now : region_q;
   assign sel = (as_n || fc == FC_IACK) ? 6'b000000 : sel_of(sel_region);

   always_comb begin
      case (region_q)
         R_TILE:  ready = tile_ready;
         R_NONE:  ready = 1'b0;
         default: ready = 1'b1;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      region_d = region_q;
      rw_d     = rw_q;
      wcnt_d   = wcnt_q;
      tcnt_d   = tcnt_q;
      unique case (state_q)
         S_IDLE: begin
            wcnt_d = 4'd0;
            tcnt_d = 8'd0;
            if (!term) begin
               rw_d = rw;
               if (fc == FC_IACK) begin
                  region_d = R_NONE;
                  state_d  = S_IACK;
               end else begin
                  region_d = region_now;
                  wcnt_d   = ws_of(region_now);
                  state_d  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            wcnt_d = (wcnt_q == 4'd0) ? 4'd0 : wcnt_q - 4'd1;
            tcnt_d = (tcnt_q == TC_LAST) ? tcnt_q : tcnt_q + 8'd1;
            // Acknowledge wins over timeout on the same edge.
            if (wcnt_q == 4'd0 && ready) begin
               state_d = S_ACK;
            end else if (tcnt_q == TC_LAST) begin
               state_d = S_BERR;
            end
         end
         S_ACK, S_IACK, S_BERR: begin
            state_d = state_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Termination overrides every other transition, including aborts.
      if (state_q != S_IDLE && term) begin
         state_d = S_IDLE;
         wcnt_d  = 4'd0;
         tcnt_d  = 8'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         region_q <= R_NONE;
         rw_q     <= 1'b1;
         wcnt_q   <= 4'd0;
         tcnt_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         rw_q     <= rw_d;
         wcnt_q   <= wcnt_d;
         tcnt_q   <= tcnt_d;
      end
   end

   // Strobes are flops so they cannot glitch; VPA waits one full IACK
   // cycle before asserting, giving the CPU's VPA path a clean setup.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dtack_q <= 1'b1;
         vpa_q   <= 1'b1;
         berr_q  <= 1'b1;
      end else begin
         dtack_q <= (state_d != S_ACK);
         berr_q  <= (state_d != S_BERR);
         vpa_q   <= !(state_q == S_IACK && state_d == S_IACK);
      end
   end

   assign dtack_n = dtack_q;
   assign vpa_n   = vpa_q;
   assign berr_n  = berr_q;
   assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed and random bus cycles
// on two instances (default timeout and timeout of 4).
module tb_cpu_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       as_n;
   logic [1:0] ds_n;
   logic       rw;
   logic [2:0] fc;
   logic [7:0] addr_hi;
   logic       tile_ready;

   logic [5:0] sel_a;
   logic       dtack_a;
   logic       vpa_a;
   logic       berr_a;
   logic       busy_a;
   logic [5:0] sel_b;
   logic       dtack_b;
   logic       vpa_b;
   logic       berr_b;
   logic       busy_b;

   int n_assert = 0;
   int n_fail   = 0;

   // Wait states per region index: rom, ram, tick, crtc, tile, pal.
   int ws_tab [6] = '{1, 0, 0, 1, 2, 1};

   cpu_bus_ctrl dut_a (
      .clk        (clk),
      .reset      (reset),
      .as_n       (as_n),
      .ds_n       (ds_n),
      .rw         (rw),
      .fc         (fc),
      .addr_hi    (addr_hi),
      .tile_ready (tile_ready),
      .sel        (sel_a),
      .dtack_n    (dtack_a),
      .vpa_n      (vpa_a),
      .berr_n     (berr_a),
      .busy       (busy_a)
   );

   cpu_bus_ctrl #(.TIMEOUT(4)) dut_b (
      .clk        (clk),
      .reset      (reset),
      .as_n       (as_n),
      .ds_n       (ds_n),
      .rw         (rw),
      .fc         (fc),
      .addr_hi    (addr_hi),
      .tile_ready (tile_ready),
      .sel        (sel_b),
      .dtack_n    (dtack_b),
      .vpa_n      (vpa_b),
      .berr_n     (berr_b),
      .busy       (busy_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory map: 0 rom, 1 ram, 2 tick, 3 crtc, 4 tile, 5 pal, 6 none.
   function automatic int reg_of(input logic [7:0] a);
      if (a < 8'h10) return 0;
      if (a == 8'h10) return 1;
      if (a == 8'h20) return 2;
      if (a == 8'h80) return 3;
      if (a == 8'h90) return 4;
      if (a == 8'h91) return 5;
      return 6;
   endfunction

   function automatic logic [5:0] onehot(input int r);
      logic [5:0] s;
      s = 6'd0;
      if (r < 6) s[r] = 1'b1;
      return s;
   endfunction

   // Edge (counted from the sampling edge 0) at which the acknowledge
   // condition is first met; ready for tile is "edge >= rdy_edge".
   function automatic int ack_edge(input int r, input int rdy_edge);
      int w;
      if (r == 6) return 100000;
      w = ws_tab[r] + 1;
      if (r == 4 && rdy_edge > w) return rdy_edge;
      return w;
   endfunction

   task automatic chk_edge(input string tag, input int e, input int len,
                           input bit iack, input int ae, input int tmo,
                           input logic dt, input logic vp,
                           input logic be, input logic bs);
      bit   live;
      logic x_dt;
      logic x_vp;
      logic x_be;
      live = (e < len);
      x_vp = !(iack && live && e >= 1);
      x_dt = !(!iack && ae <= tmo && live && e >= ae);
      x_be = !(!iack && ae > tmo && live && e >= tmo);
      chk($sformatf("%s e%0d dtack", tag, e), {7'd0, dt}, {7'd0, x_dt});
      chk($sformatf("%s e%0d vpa", tag, e), {7'd0, vp}, {7'd0, x_vp});
      chk($sformatf("%s e%0d berr", tag, e), {7'd0, be}, {7'd0, x_be});
      chk($sformatf("%s e%0d busy", tag, e), {7'd0, bs}, {7'd0, live});
   endtask

   // One bus cycle: strobes low for edges 0..len-1, termination seen at
   // edge len. ds_only ends the cycle with data strobes alone.
   task automatic run(input string tag, input logic [7:0] a,
                      input logic [2:0] f, input logic [1:0] ds,
                      input int len, input int rdy_edge, input bit ds_only);
      int         r;
      int         ae;
      logic [5:0] x_sel;
      r  = reg_of(a);
      ae = ack_edge(r, rdy_edge);
      addr_hi    = a;
      fc         = f;
      ds_n       = ds;
      as_n       = 1'b0;
      rw         = 1'($urandom);
      tile_ready = (rdy_edge <= 0);
      x_sel = (f == 3'b111) ? 6'd0 : onehot(r);
      #1;
      chk({tag, " pre sel"}, {2'b0, sel_a}, {2'b0, x_sel});
      for (int e = 0; e <= len; e++) begin
         @(posedge clk);
         #1;
         chk_edge({tag, " A"}, e, len, f == 3'b111, ae, 64,
                  dtack_a, vpa_a, berr_a, busy_a);
         chk_edge({tag, " B"}, e, len, f == 3'b111, ae, 4,
                  dtack_b, vpa_b, berr_b, busy_b);
         if (e == len) begin
            x_sel = (as_n || fc == 3'b111) ? 6'd0 : onehot(reg_of(addr_hi));
         end
         chk($sformatf("%s e%0d sel", tag, e), {2'b0, sel_a}, {2'b0, x_sel});
         chk($sformatf("%s e%0d selb", tag, e), {2'b0, sel_b}, {2'b0, x_sel});
         if (e == 0) addr_hi = 8'($urandom);
         tile_ready = (e + 1 >= rdy_edge);
         if (e + 1 == len) begin
            ds_n = 2'b11;
            if (!ds_only) as_n = 1'b1;
         end
      end
      as_n       = 1'b1;
      ds_n       = 2'b11;
      tile_ready = 1'b0;
   endtask

   initial begin
      int         k;
      logic [7:0] a;
      logic [2:0] f;

      reset      = 1'b1;
      as_n       = 1'b1;
      ds_n       = 2'b11;
      rw         = 1'b1;
      fc         = 3'b001;
      addr_hi    = 8'h00;
      tile_ready = 1'b0;
      #1;
      chk("reset dtack", {7'd0, dtack_a}, 8'd1);
      chk("reset vpa", {7'd0, vpa_a}, 8'd1);
      chk("reset berr", {7'd0, berr_a}, 8'd1);
      chk("reset busy", {7'd0, busy_a}, 8'd0);
      chk("reset sel", {2'b0, sel_a}, 8'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle busy", {7'd0, busy_a}, 8'd0);

      run("ram", 8'h10, 3'b001, 2'b00, 3, 0, 1'b0);
      run("tile", 8'h90, 3'b001, 2'b00, 10, 7, 1'b0);
      run("iack", 8'h10, 3'b111, 2'b00, 4, 0, 1'b0);
      run("unmapped", 8'h40, 3'b001, 2'b00, 67, 0, 1'b0);
      run("abort", 8'h80, 3'b010, 2'b00, 1, 0, 1'b0);
      run("race", 8'h90, 3'b001, 2'b01, 8, 4, 1'b0);
      run("rom ds", 8'h05, 3'b110, 2'b10, 5, 0, 1'b1);
      run("pal", 8'h91, 3'b001, 2'b00, 4, 0, 1'b0);
      run("tick", 8'h20, 3'b101, 2'b00, 3, 0, 1'b0);

      // Reset pulse while DTACK is asserted must release it at once.
      addr_hi = 8'h10;
      fc      = 3'b001;
      ds_n    = 2'b00;
      as_n    = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst ack held", {7'd0, dtack_a}, 8'd0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst async dtack", {7'd0, dtack_a}, 8'd1);
      chk("rst async dtackb", {7'd0, dtack_b}, 8'd1);
      chk("rst async busy", {7'd0, busy_a}, 8'd0);
      as_n = 1'b1;
      ds_n = 2'b11;
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("rst after idle", {7'd0, busy_a}, 8'd0);

      for (int i = 0; i < 40; i++) begin
         k = $urandom_range(0, 7);
         case (k)
            0:       a = 8'($urandom_range(0, 15));
            1:       a = 8'h10;
            2:       a = 8'h20;
            3:       a = 8'h80;
            4:       a = 8'h90;
            5:       a = 8'h91;
            default: a = 8'($urandom);
         endcase
         if ($urandom_range(0, 5) == 0) f = 3'b111;
         else f = 3'($urandom_range(0, 6));
         run($sformatf("rnd%0d", i), a, f, 2'($urandom_range(0, 2)),
             $urandom_range(1, 20), $urandom_range(0, 12),
             1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
